// File: rtl/udp_tx_arbiter_if.sv
// Bundle of requester-side and TX-engine-side AXI-Stream signals for the
// UDP TX arbiter. The slave modport is the arbiter's view: it accepts the
// requester streams and drives the merged stream toward the TX engine.
// The master modport is the surrounding environment's view.
interface udp_tx_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_PORTS  = 4
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UDP TX user stream between
// NUM_PORTS requesters. A grant is held from the arbitration cycle until the
// tlast handshake, so packets from different requesters never interleave.
// Per-port packet counters report how many packets each requester forwarded.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; outputs quiet; picks next requester if arb_enable
// BUSY  | grant_id owns the output stream until its tlast is accepted
module udp_tx_arbiter #(
  parameter int DATA_WIDTH    = 512,
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS),
  parameter int CNT_WIDTH     = 32
) (
  input  logic                           tx_axis_aclk,
  input  logic                           tx_axis_aresetn,
  input  logic                           arb_enable,
  udp_tx_arbiter_if.slave                axis,
  output logic                           grant_valid,
  output logic [PORT_ID_WIDTH-1:0]       grant_id,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_count
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [PORT_ID_WIDTH-1:0]  last_grant_q;
  logic [PORT_ID_WIDTH-1:0]  sel_idx;
  logic                      sel_found;
  logic                      grant_load;
  logic                      grant_release;
  logic [CNT_WIDTH-1:0]      cnt_q [NUM_PORTS];

  logic [DATA_WIDTH-1:0]     m_tdata_c;
  logic [KEEP_WIDTH-1:0]     m_tkeep_c;
  logic                      m_tvalid_c;
  logic                      m_tlast_c;
  logic [NUM_PORTS-1:0]      s_tready_c;
  logic                      beat_done;

  // Round-robin search: first valid port after last_grant, wrapping modulo
  // NUM_PORTS so non-power-of-two port counts rotate correctly.
  always_comb begin
    int p;
    sel_found = 1'b0;
    sel_idx   = '0;
    p         = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!sel_found && axis.s_axis_tvalid[p]) begin
        sel_found = 1'b1;
        sel_idx   = PORT_ID_WIDTH'(p);
      end
    end
  end

  // Combinational mux from the granted port; everything is quiet while IDLE.
  always_comb begin
    m_tdata_c  = '0;
    m_tkeep_c  = '0;
    m_tvalid_c = 1'b0;
    m_tlast_c  = 1'b0;
    s_tready_c = '0;
    if (state_q == BUSY) begin
      m_tdata_c            = axis.s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      m_tkeep_c            = axis.s_axis_tkeep[int'(grant_id)*KEEP_WIDTH +: KEEP_WIDTH];
      m_tvalid_c           = axis.s_axis_tvalid[grant_id];
      m_tlast_c            = axis.s_axis_tlast[grant_id];
      s_tready_c[grant_id] = axis.m_axis_tready;
    end
  end

  assign beat_done          = m_tvalid_c & axis.m_axis_tready & m_tlast_c;
  assign axis.m_axis_tdata  = m_tdata_c;
  assign axis.m_axis_tkeep  = m_tkeep_c;
  assign axis.m_axis_tvalid = m_tvalid_c;
  assign axis.m_axis_tlast  = m_tlast_c;
  assign axis.s_axis_tready = s_tready_c;

  // Next-state logic: grant on any request while enabled, release on tlast.
  always_comb begin
    state_d       = state_q;
    grant_load    = 1'b0;
    grant_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_enable && sel_found) begin
          state_d    = BUSY;
          grant_load = 1'b1;
        end
      end
      BUSY: begin
        if (beat_done) begin
          state_d       = IDLE;
          grant_release = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state_q      <= IDLE;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      last_grant_q <= PORT_ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        grant_valid <= 1'b1;
        grant_id    <= sel_idx;
      end else if (grant_release) begin
        grant_valid  <= 1'b0;
        last_grant_q <= grant_id;
      end
    end
  end

  // Per-port packet counters, bumped on the accepted tlast beat; wrap freely.
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (grant_release) begin
      cnt_q[grant_id] <= cnt_q[grant_id] + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized scoreboard bench for udp_tx_arbiter. A reference model applies
// the arbitration rules each cycle and queues expected control state and
// accepted beats; an independent monitor pops and compares.
module tb_udp_tx_arbiter;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  logic arb_enable = 1'b0;
  logic en3 = 1'b0;
  always #5 clk = ~clk;

  udp_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();
  udp_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(3))  bus3 ();

  logic          grant_valid;
  logic [PW-1:0] grant_id;
  logic [NP*CW-1:0] pkt_count;
  logic          grant3_valid;
  logic [1:0]    grant3_id;
  logic [3*CW-1:0] pkt_count3;

  udp_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n), .arb_enable(arb_enable),
    .axis(bus.slave), .grant_valid(grant_valid), .grant_id(grant_id),
    .pkt_count(pkt_count));

  udp_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(3), .CNT_WIDTH(CW)) dut3 (
    .tx_axis_aclk(clk), .tx_axis_aresetn(rst3_n), .arb_enable(en3),
    .axis(bus3.slave), .grant_valid(grant3_valid), .grant_id(grant3_id),
    .pkt_count(pkt_count3));

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [PW-1:0] port;
  } beat_t;

  typedef struct {
    logic          busy;
    logic [PW-1:0] gid;
  } ctl_t;

  beat_t pq [NP][$];
  beat_t exp_q [$];
  ctl_t  ctl_q [$];
  int    g3_q [$];

  int tests = 0;
  int fails = 0;
  int valid_pct = 100;
  int ready_pct = 100;
  int en_pct = 100;
  bit ready_alt = 1'b0;

  logic          m_busy;
  logic [PW-1:0] m_gid;
  int            m_last;
  int            exp_cnt [NP];
  logic [NP-1:0] hs;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the stream and which beats must appear.
  always @(negedge clk) begin : model
    beat_t b;
    int p;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_gid  = '0;
      m_last = NP - 1;
      for (int i = 0; i < NP; i++) exp_cnt[i] = 0;
    end else begin
      ctl_q.push_back('{m_busy, m_gid});
      if (m_busy) begin
        if (bus.s_axis_tvalid[m_gid] && bus.m_axis_tready) begin
          b.data = bus.s_axis_tdata[m_gid*DW +: DW];
          b.keep = bus.s_axis_tkeep[m_gid*KW +: KW];
          b.last = bus.s_axis_tlast[m_gid];
          b.port = m_gid;
          exp_q.push_back(b);
          if (b.last) begin
            m_busy = 1'b0;
            m_last = int'(m_gid);
            exp_cnt[m_gid]++;
          end
        end
      end else if (arb_enable && (|bus.s_axis_tvalid)) begin
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (!m_busy && bus.s_axis_tvalid[p]) begin
            m_busy = 1'b1;
            m_gid  = PW'(p);
          end
        end
      end
    end
  end

  // Monitor: compare DUT against the queued expectations.
  always @(negedge clk) begin : monitor
    ctl_t  c;
    beat_t e;
    #1;
    if (rst_n) begin
      if (ctl_q.size() == 0) begin
        chk("ctl_queue_empty", 1, 0);
      end else begin
        c = ctl_q.pop_front();
        chk("grant_valid", grant_valid, c.busy);
        if (c.busy) chk("grant_id", grant_id, c.gid);
        chk("s_tready", bus.s_axis_tready,
            c.busy ? (NP'(bus.m_axis_tready) << c.gid) : '0);
        chk("m_tvalid", bus.m_axis_tvalid, c.busy ? bus.s_axis_tvalid[c.gid] : 1'b0);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", bus.m_axis_tdata, e.data);
          chk("m_tkeep", bus.m_axis_tkeep, e.keep);
          chk("m_tlast", bus.m_axis_tlast, e.last);
          chk("beat_port", grant_id, e.port);
        end
      end
    end
  end

  always @(negedge clk) hs = bus.s_axis_tvalid & bus.s_axis_tready;

  // Requester drivers: each port presents its own beat queue, holding a beat
  // until it is accepted.
  always @(posedge clk) begin : driver
    #1;
    if (!rst_n) begin
      bus.s_axis_tvalid = '0;
      bus.s_axis_tlast  = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        if (!(bus.s_axis_tvalid[p] && !hs[p])) begin
          if (pq[p].size() > 0 && $urandom_range(99) < valid_pct) begin
            bus.s_axis_tvalid[p]          = 1'b1;
            bus.s_axis_tdata[p*DW +: DW]  = pq[p][0].data;
            bus.s_axis_tkeep[p*KW +: KW]  = pq[p][0].keep;
            bus.s_axis_tlast[p]           = pq[p][0].last;
          end else begin
            bus.s_axis_tvalid[p] = 1'b0;
          end
        end
      end
    end
  end

  // Downstream ready and enable knobs.
  always @(posedge clk) begin : knobs
    #1;
    if (ready_alt) bus.m_axis_tready = ~bus.m_axis_tready;
    else           bus.m_axis_tready = ($urandom_range(99) < ready_pct);
    arb_enable = ($urandom_range(99) < en_pct);
  end

  // Three-port instance: record the port of each accepted single-beat packet.
  always @(negedge clk) begin : rec3
    if (rst3_n && bus3.m_axis_tvalid && bus3.m_axis_tready && g3_q.size() < 6) begin
      g3_q.push_back(int'(grant3_id));
      if (g3_q.size() == 6) en3 = 1'b0;
    end
  end

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == len - 1) ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
      b.last = (i == len - 1);
      b.port = PW'(p);
      pq[p].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int p = 0; p < NP; p++) if (pq[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pending() || grant_valid || exp_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 1, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_counts();
    for (int p = 0; p < NP; p++) chk("pkt_count", pkt_count[p*CW +: CW], exp_cnt[p]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    bus3.s_axis_tdata  = '0;
    bus3.s_axis_tkeep  = '1;
    bus3.s_axis_tvalid = 3'b111;
    bus3.s_axis_tlast  = 3'b111;
    bus3.m_axis_tready = 1'b1;

    #12;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    @(posedge clk); #3;
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    en3    = 1'b1;

    // Single requester, three-beat packet.
    add_pkt(2, 3);
    wait_idle(200);
    chk("p2_single_count", pkt_count[2*CW +: CW], 1);

    // All ports contending with two-beat packets.
    for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) add_pkt(p, 2);
    wait_idle(500);
    check_counts();

    // Downstream ready toggling during a four-beat packet.
    ready_alt = 1'b1;
    add_pkt(0, 4);
    wait_idle(200);
    ready_alt = 1'b0;
    check_counts();

    // Randomized contention with stalls, valid gaps and enable toggling.
    valid_pct = 80;
    ready_pct = 70;
    en_pct    = 85;
    for (int i = 0; i < 150; i++) add_pkt($urandom_range(NP - 1), $urandom_range(1, 5));
    wait_idle(20000);
    check_counts();

    // Long enable-off window with a request pending: nothing may be granted.
    valid_pct = 100;
    ready_pct = 100;
    en_pct    = 0;
    repeat (2) @(posedge clk);
    add_pkt(3, 2);
    repeat (10) @(posedge clk);
    #4;
    chk("disabled_no_grant", grant_valid, 0);
    en_pct = 100;
    wait_idle(200);
    check_counts();

    // Reset in the middle of a packet.
    add_pkt(1, 6);
    n = 0;
    while (!grant_valid && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) chk("wait_grant_timeout", 1, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("async_rst_grant_valid", grant_valid, 0);
    chk("async_rst_s_tready", bus.s_axis_tready, 0);
    chk("async_rst_pkt_count", pkt_count, 0);
    for (int p = 0; p < NP; p++) pq[p].delete();
    exp_q.delete();
    ctl_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    add_pkt(0, 2);
    add_pkt(1, 2);
    n = 0;
    while (!grant_valid && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) chk("wait_grant_timeout", 1, 0);
    chk("post_rst_first_grant", grant_id, 0);
    wait_idle(200);
    check_counts();

    // Three-port build: rotation must wrap 2 -> 0.
    n = 0;
    while (g3_q.size() < 6 && n < 200) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    if (g3_q.size() < 6) chk("np3_grant_timeout", g3_q.size(), 6);
    else for (int i = 0; i < 6; i++) chk("np3_grant_order", g3_q[i], i % 3);
    for (int p = 0; p < 3; p++) chk("np3_pkt_count", pkt_count3[p*CW +: CW], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single UDP TX user stream of the Ethernet TX engine between NUM_PORTS requesters (RPC engines, host DMA, test generator).
- Locks grant from first beat to tlast, so packets never interleave.
- Output drives the TX engine's udp_tx_axis_* input directly; per-port packet counters provide status.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits.
- NUM_PORTS, 4, number of requesters (2..16).
- PORT_ID_WIDTH, $clog2(NUM_PORTS), width of grant index.
- CNT_WIDTH, 32, width of per-port packet counters.

Ports:
- tx_axis_aclk  in  1  clock
- tx_axis_aresetn  in  1  asynchronous active-low reset
- arb_enable  in  1  when low, no new grants are issued; a packet in flight completes
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  requester keep
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  to TX engine
- m_axis_tkeep  out  DATA_WIDTH/8  to TX engine
- m_axis_tvalid  out  1  to TX engine
- m_axis_tlast  out  1  to TX engine
- m_axis_tready  in  1  from TX engine
- grant_valid  out  1  a port currently holds the grant (state BUSY)
- grant_id  out  PORT_ID_WIDTH  index of granted port
- pkt_count  out  NUM_PORTS*CNT_WIDTH  packets forwarded per port; port i at [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Reset (async assert, sync deassert by the clock edge): state=IDLE, grant_valid=0, grant_id=0, last_grant=NUM_PORTS-1 (so port 0 wins first), all pkt_count=0. s_axis_tready=0, m_axis_tvalid=0. Reset mid-packet abandons the packet immediately; no resume.
- States:
  - IDLE: if arb_enable and any s_axis_tvalid, select the first valid port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS. Register it into grant_id, set grant_valid=1, go to BUSY. Otherwise stay.
  - BUSY: datapath is combinational from granted port. m_axis_{tdata,tkeep,tlast,tvalid} = s_axis_*[grant_id]; s_axis_tready[grant_id] = m_axis_tready; all other tready=0. On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: pkt_count[grant_id]++ (wraps to 0 at all-ones), last_grant<=grant_id, grant_valid<=0, go to IDLE.
- In IDLE all m_axis_* outputs=0 and all s_axis_tready=0.
- Latency: one arbitration cycle per packet. First beat of a request presented at cycle N is accepted no earlier than N+1. Back-to-back packets have a 1-cycle bubble.
- Fairness: a port with continuous valid waits at most NUM_PORTS-1 packets.
- arb_enable deassert during BUSY: no effect until tlast, then IDLE holds. Deassert and reassert while IDLE just resumes. last_grant is preserved.
- Requester dropping tvalid mid-packet: grant is held and m_axis_tvalid follows it low; no timeout.
- tvalid low on the granted port in BUSY is legal; m_axis_tvalid=0 that cycle.
- Single-beat packet (tvalid & tlast on first beat): IDLE→BUSY→IDLE, count+1.
- A tlast beat stalled by m_axis_tready=0 keeps the grant; counting happens only on the handshake.
- Widths: grant_id compare and increment are modulo NUM_PORTS (non-power-of-2 NUM_PORTS must wrap correctly, e.g. 2→0 for NUM_PORTS=3).

Test Plan:
- Reset, then port 2 only sends a 3-beat packet, m_axis_tready=1 → grant_id=2 one cycle after valid; 3 output beats with port 2 data; tlast on beat 3; pkt_count[2]=1; IDLE afterwards.
- All 4 ports continuously valid, each sending 2-beat packets, tready=1 → grant order 0,1,2,3,0,1...; 3 cycles per packet (1 arb + 2 data); after 8 packets every pkt_count=2.
- Port 1 mid-packet, port 0 asserts valid → no interleave; port 0 granted only after port 1's tlast handshake.
- m_axis_tready toggles 1,0,1,0 during a 4-beat packet → upstream tready mirrors it exactly; no beat duplicated or lost; pkt_count increments once, on the final accepted beat.
- arb_enable dropped on beat 2 of a 4-beat packet with port 3 pending → current packet completes; no new grant while disabled; port 3 granted one cycle after re-enable.
- Reset asserted mid-packet → all outputs 0 asynchronously; counters=0; after release, port 0 wins a simultaneous 0/1 request; NUM_PORTS=3 build wraps grant 2→0.
